// File: rtl/output_sequencer.sv
// ---------------------------------------------------------------------------
// output_sequencer
//
// Output-side controller for the stereo filter datapath. Collects the left
// and right convolution results, pairs them into a small FIFO and, once per
// accepted frame strobe, shifts one pair out MSB first on two serial lines.
//
// Parameters
//   WIDTH     result width and number of serial bits per frame
//   DEPTH     pair buffer entries (power of 2, at least 2)
//
// Ports
//   sClk      in   system clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   doneL     in   one-cycle pulse, resultL valid
//   resultL   in   left channel result  [WIDTH-1:0]
//   doneR     in   one-cycle pulse, resultR valid
//   resultR   in   right channel result [WIDTH-1:0]
//   Frame     in   output frame strobe
//   outReady  out  high during the WIDTH serial data cycles
//   outDataL  out  left serial bit
//   outDataR  out  right serial bit
//   busy      out  high whenever the sequencer is not idle
//   overflow  out  sticky error flag, cleared only by reset
//   ovfCount  out  saturating overflow event counter [7:0]
//                  (only when OUTSEQ_OVF_COUNT_EN is defined)
//
// Build option
//   OUTSEQ_OVF_COUNT_EN  adds the ovfCount port and its counter.
//
// State table
//   state      | meaning
//   IDLE       | buffer empty, Frame ignored
//   WAIT_FRAME | pair available, waiting for a Frame strobe to start
//   SHIFT      | shifting a pair out, outReady high, Frame ignored
// ---------------------------------------------------------------------------
module output_sequencer #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic             sClk,
  input  logic             Reset_n,
  input  logic             doneL,
  input  logic [WIDTH-1:0] resultL,
  input  logic             doneR,
  input  logic [WIDTH-1:0] resultR,
  input  logic             Frame,
  output logic             outReady,
  output logic             outDataL,
  output logic             outDataR,
  output logic             busy,
  output logic             overflow
`ifdef OUTSEQ_OVF_COUNT_EN
  ,
  output logic [7:0]       ovfCount
`endif
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam int CNTW  = $clog2(WIDTH);
  localparam logic [CNTW-1:0]  LAST_BIT = CNTW'(WIDTH - 1);
  localparam logic [ADDRW:0]   FULL_CNT = (ADDRW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    SHIFT      = 2'd2
  } stateT;

  stateT state;

  // pending results waiting for their partner channel
  logic [WIDTH-1:0] pendL;
  logic [WIDTH-1:0] pendR;
  logic             vL;
  logic             vR;

  // pair buffer; pointers wrap naturally because DEPTH is a power of 2
  logic [WIDTH-1:0] bufL [DEPTH];
  logic [WIDTH-1:0] bufR [DEPTH];
  logic [ADDRW-1:0] rdPtr;
  logic [ADDRW-1:0] wrPtr;
  logic [ADDRW:0]   count;

  logic [WIDTH-1:0] shiftL;
  logic [WIDTH-1:0] shiftR;
  logic [CNTW-1:0]  bitCnt;

  logic           pushReq;
  logic           full;
  logic           pushOk;
  logic           pop;
  logic           ovfEvent;
  logic [ADDRW:0] countNext;

  always_comb begin
    pushReq   = vL && vR;
    full      = (count == FULL_CNT);
    // a push into a full buffer is dropped even if a pop happens this cycle
    pushOk    = pushReq && !full;
    pop       = (state == WAIT_FRAME) && Frame;
    ovfEvent  = (pushReq && full)
              || (doneL && vL && !pushReq)
              || (doneR && vR && !pushReq);
    countNext = count + (ADDRW + 1)'(pushOk) - (ADDRW + 1)'(pop);
  end

  // pairing, buffer pointers and error flag
  always_ff @(posedge sClk or negedge Reset_n) begin
    if (!Reset_n) begin
      pendL    <= '0;
      pendR    <= '0;
      vL       <= 1'b0;
      vR       <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doneL) begin
        pendL <= resultL;
      end
      if (doneR) begin
        pendR <= resultR;
      end
      // a done arriving with the push starts the next pair
      vL <= doneL || (vL && !pushReq);
      vR <= doneR || (vR && !pushReq);
      if (pushOk) begin
        wrPtr <= wrPtr + ADDRW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + ADDRW'(1);
      end
      count <= countNext;
      if (ovfEvent) begin
        overflow <= 1'b1;
      end
    end
  end

  // storage needs no reset; occupancy is tracked by count
  always_ff @(posedge sClk) begin
    if (pushOk) begin
      bufL[wrPtr] <= pendL;
      bufR[wrPtr] <= pendR;
    end
  end

`ifdef OUTSEQ_OVF_COUNT_EN
  always_ff @(posedge sClk or negedge Reset_n) begin
    if (!Reset_n) begin
      ovfCount <= 8'd0;
    end else if (ovfEvent && (ovfCount != 8'hFF)) begin
      ovfCount <= ovfCount + 8'd1;
    end
  end
`endif

  // sequencing FSM; serial outputs are registered from the SHIFT state so
  // the MSB appears one edge after the accepting Frame edge
  always_ff @(posedge sClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      shiftL   <= '0;
      shiftR   <= '0;
      bitCnt   <= '0;
      outReady <= 1'b0;
      outDataL <= 1'b0;
      outDataR <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          outReady <= 1'b0;
          outDataL <= 1'b0;
          outDataR <= 1'b0;
          if (count != '0) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        WAIT_FRAME: begin
          outReady <= 1'b0;
          outDataL <= 1'b0;
          outDataR <= 1'b0;
          busy     <= 1'b1;
          if (Frame) begin
            shiftL <= bufL[rdPtr];
            shiftR <= bufR[rdPtr];
            bitCnt <= LAST_BIT;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          outReady <= 1'b1;
          outDataL <= shiftL[WIDTH-1];
          outDataR <= shiftR[WIDTH-1];
          shiftL   <= shiftL << 1;
          shiftR   <= shiftR << 1;
          bitCnt   <= bitCnt - CNTW'(1);
          if (bitCnt == '0) begin
            // no pop can happen here, so countNext only reflects a push
            if (countNext != '0) begin
              state <= WAIT_FRAME;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            busy <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          outReady <= 1'b0;
          outDataL <= 1'b0;
          outDataR <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Testbench for output_sequencer: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_output_sequencer;

  localparam int W = 40;
  localparam int D = 2;
  localparam int PH_IDLE  = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_TX    = 2;

  logic         sClk = 1'b0;
  logic         Reset_n;
  logic         doneL;
  logic [W-1:0] resultL;
  logic         doneR;
  logic [W-1:0] resultR;
  logic         Frame;
  logic         outReady;
  logic         outDataL;
  logic         outDataR;
  logic         busy;
  logic         overflow;
`ifdef OUTSEQ_OVF_COUNT_EN
  logic [7:0]   ovfCount;
`endif

  output_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .sClk     (sClk),
    .Reset_n  (Reset_n),
    .doneL    (doneL),
    .resultL  (resultL),
    .doneR    (doneR),
    .resultR  (resultR),
    .Frame    (Frame),
    .outReady (outReady),
    .outDataL (outDataL),
    .outDataR (outDataR),
    .busy     (busy),
    .overflow (overflow)
`ifdef OUTSEQ_OVF_COUNT_EN
    ,
    .ovfCount (ovfCount)
`endif
  );

  always #5 sClk = ~sClk;

  int vecCount = 0;
  int errCount = 0;

  task automatic checkVal(string tag, logic [63:0] got, logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: pending slots, a pair queue and a bit-countdown per frame
  logic [W-1:0]   mPendL, mPendR, mTxL, mTxR;
  bit             mHasL, mHasR, mOvf;
  logic [2*W-1:0] mq[$];
  int             mPhase, mLeft, mOvfCnt;
  bit             expReady, expL, expR;

  // observed serial words
  logic [W-1:0] obsL, obsR;
  logic [W-1:0] obsQL[$];
  logic [W-1:0] obsQR[$];
  int           readyCycles;
  bit           prevReady;

  function automatic logic [W-1:0] randWord();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic modelReset();
    mPendL = '0; mPendR = '0; mTxL = '0; mTxR = '0;
    mHasL = 0; mHasR = 0; mOvf = 0; mOvfCnt = 0;
    mq.delete();
    mPhase = PH_IDLE; mLeft = 0;
    expReady = 0; expL = 0; expR = 0;
  endtask

  task automatic clearObs();
    obsL = '0; obsR = '0; readyCycles = 0; prevReady = 0;
    obsQL.delete(); obsQR.delete();
  endtask

  // effect of the coming rising edge given the inputs currently driven
  task automatic modelStep();
    bit full, pushReq, pushOk, pop, ovf;
    int preSize;
    logic [2*W-1:0] w;
    preSize = mq.size();
    full    = (preSize == D);
    pushReq = mHasL && mHasR;
    pushOk  = pushReq && !full;
    pop     = (mPhase == PH_ARMED) && Frame;
    ovf     = (pushReq && full) || (doneL && mHasL && !pushReq) || (doneR && mHasR && !pushReq);
    if (mPhase == PH_TX) begin
      expReady = 1; expL = mTxL[mLeft-1]; expR = mTxR[mLeft-1];
    end else begin
      expReady = 0; expL = 0; expR = 0;
    end
    if (pop) begin
      w = mq.pop_front();
      mTxL = w[2*W-1:W];
      mTxR = w[W-1:0];
    end
    if (pushOk) mq.push_back({mPendL, mPendR});
    case (mPhase)
      PH_IDLE:  if (preSize > 0) mPhase = PH_ARMED;
      PH_ARMED: if (pop) begin mPhase = PH_TX; mLeft = W; end
      default: begin
        mLeft--;
        if (mLeft == 0) mPhase = (mq.size() > 0) ? PH_ARMED : PH_IDLE;
      end
    endcase
    if (pushReq) begin mHasL = 0; mHasR = 0; end
    if (doneL) begin mPendL = resultL; mHasL = 1; end
    if (doneR) begin mPendR = resultR; mHasR = 1; end
    if (ovf) begin
      mOvf = 1;
      if (mOvfCnt < 255) mOvfCnt++;
    end
  endtask

  task automatic compareAll();
    checkVal("outReady", 64'(outReady), 64'(expReady));
    checkVal("outDataL", 64'(outDataL), 64'(expL));
    checkVal("outDataR", 64'(outDataR), 64'(expR));
    checkVal("busy", 64'(busy), 64'(mPhase != PH_IDLE));
    checkVal("overflow", 64'(overflow), 64'(mOvf));
`ifdef OUTSEQ_OVF_COUNT_EN
    checkVal("ovfCount", 64'(ovfCount), 64'(mOvfCnt));
`endif
    if (outReady) begin
      obsL = {obsL[W-2:0], outDataL};
      obsR = {obsR[W-2:0], outDataR};
      readyCycles++;
    end
    if (prevReady && !outReady) begin
      obsQL.push_back(obsL);
      obsQR.push_back(obsR);
    end
    prevReady = outReady;
  endtask

  // called at a falling edge: drive, predict, advance one clock, compare
  task automatic cycle(bit dL, logic [W-1:0] rL, bit dR, logic [W-1:0] rR, bit fr);
    doneL = dL; resultL = rL; doneR = dR; resultR = rR; Frame = fr;
    modelStep();
    @(posedge sClk);
    @(negedge sClk);
    compareAll();
  endtask

  task automatic idle(int n, bit fr);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, fr);
  endtask

  task automatic applyReset();
    Reset_n = 0; doneL = 0; doneR = 0; Frame = 0; resultL = '0; resultR = '0;
    modelReset();
    @(posedge sClk);
    @(negedge sClk);
    compareAll();
    Reset_n = 1;
    clearObs();
  endtask

  task automatic checkWord(string tag, int idx, logic [W-1:0] eL, logic [W-1:0] eR);
    if (idx < obsQL.size()) begin
      checkVal({tag, "_L"}, 64'(obsQL[idx]), 64'(eL));
      checkVal({tag, "_R"}, 64'(obsQR[idx]), 64'(eR));
    end else begin
      checkVal({tag, "_count"}, 64'(obsQL.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    Reset_n = 0; doneL = 0; doneR = 0; Frame = 0; resultL = '0; resultR = '0;
    modelReset();
    clearObs();
    @(negedge sClk);
    @(negedge sClk);
    compareAll();
    Reset_n = 1;

    // single pair, known bit pattern
    applyReset();
    cycle(1, 40'h80_0000_0001, 1, 40'h00_0000_0003, 0);
    idle(3, 0);
    cycle(0, '0, 0, '0, 1);
    idle(45, 0);
    checkVal("t1_readyCycles", 64'(readyCycles), 64'd40);
    checkWord("t1_word", 0, 40'h80_0000_0001, 40'h00_0000_0003);

    // simultaneous done, Frame held high throughout
    applyReset();
    cycle(1, randWord(), 1, randWord(), 1);
    cycle(0, '0, 0, '0, 1);
    checkVal("t2_busy_push", 64'(busy), 64'd0);
    cycle(0, '0, 0, '0, 1);
    checkVal("t2_busy_next", 64'(busy), 64'd1);
    idle(60, 1);
    checkVal("t2_readyCycles", 64'(readyCycles), 64'd40);
    checkVal("t2_busy_end", 64'(busy), 64'd0);

    // buffer full: third pair dropped
    applyReset();
    for (int i = 1; i <= 3; i++) begin
      cycle(1, W'(i), 1, W'(8'h11 * i), 0);
      cycle(0, '0, 0, '0, 0);
    end
    checkVal("t3_overflow", 64'(overflow), 64'd1);
    cycle(0, '0, 0, '0, 1);
    idle(45, 0);
    cycle(0, '0, 0, '0, 1);
    idle(45, 0);
    checkWord("t3_first", 0, W'(1), W'(8'h11));
    checkWord("t3_second", 1, W'(2), W'(8'h22));
    checkVal("t3_frames", 64'(obsQL.size()), 64'd2);
    checkVal("t3_busy_end", 64'(busy), 64'd0);

    // repeated left done overwrites pending value
    applyReset();
    cycle(1, W'(4'hA), 0, '0, 0);
    cycle(1, W'(4'hB), 0, '0, 0);
    cycle(0, '0, 1, W'(4'h5), 0);
    idle(3, 0);
    cycle(0, '0, 0, '0, 1);
    idle(45, 0);
    checkVal("t4_overflow", 64'(overflow), 64'd1);
    checkWord("t4_word", 0, W'(4'hB), W'(4'h5));

    // reset in the middle of a frame
    applyReset();
    cycle(1, '1, 1, '1, 0);
    idle(3, 0);
    cycle(0, '0, 0, '0, 1);
    idle(20, 0);
    checkVal("t5_midframe_ready", 64'(outReady), 64'd1);
    #2;
    Reset_n = 0;
    #1;
    checkVal("t5_rst_outReady", 64'(outReady), 64'd0);
    checkVal("t5_rst_outDataL", 64'(outDataL), 64'd0);
    checkVal("t5_rst_outDataR", 64'(outDataR), 64'd0);
    checkVal("t5_rst_busy", 64'(busy), 64'd0);
    modelReset();
    @(negedge sClk);
    Reset_n = 1;
    clearObs();
    idle(50, 1);
    checkVal("t5_no_frame", 64'(readyCycles), 64'd0);

`ifdef OUTSEQ_OVF_COUNT_EN
    // counter saturation
    applyReset();
    cycle(1, W'(1), 0, '0, 0);
    for (int i = 0; i < 300; i++) cycle(1, W'(i), 0, '0, 0);
    checkVal("t6_ovfCount", 64'(ovfCount), 64'd255);
`endif

    // random traffic: sparse frames, then mostly-held frames
    applyReset();
    for (int i = 0; i < 4000; i++) begin
      bit dL, dR, fr;
      dL = ($urandom_range(0, 5) == 0);
      dR = ($urandom_range(0, 5) == 0);
      if (i < 2000) fr = ($urandom_range(0, 3) == 0);
      else          fr = ($urandom_range(0, 9) != 0);
      cycle(dL, randWord(), dR, randWord(), fr);
    end
    idle(100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
